// File: rtl/register_id_ex.sv
// ID/EX pipeline register with operand forwarding at capture, held-slot
// refresh from EX/MEM, load-use hazard detection and a saturating stall counter.
module register_id_ex #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs_addr,
    input  logic [ADDR_W-1:0] in_rt_addr,
    input  logic [DATA_W-1:0] in_rs_data,
    input  logic [DATA_W-1:0] in_rt_data,
    input  logic [ADDR_W-1:0] in_wr_addr,
    input  logic              in_mem_rd,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [ADDR_W-1:0] fwd_addr,
    input  logic [DATA_W-1:0] fwd_data,
    input  logic              fwd_en,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_rs_addr,
    output logic [ADDR_W-1:0] out_rt_addr,
    output logic [ADDR_W-1:0] out_wr_addr,
    output logic [DATA_W-1:0] out_rs_data,
    output logic [DATA_W-1:0] out_rt_data,
    output logic              out_mem_rd,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              valid_q,   valid_d;
    logic [ADDR_W-1:0] rs_addr_q, rs_addr_d;
    logic [ADDR_W-1:0] rt_addr_q, rt_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic              mem_rd_q,  mem_rd_d;
    logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    logic hazard;
    logic in_fire;
    logic out_fire;

    // Register 0 reads as zero; otherwise the in-flight EX/MEM result wins.
    function automatic logic [DATA_W-1:0] pick_operand(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] rf_data,
        input logic              f_en,
        input logic [ADDR_W-1:0] f_addr,
        input logic [DATA_W-1:0] f_data
    );
        if (addr == '0)
            return '0;
        else if (f_en && (f_addr == addr))
            return f_data;
        else
            return rf_data;
    endfunction

    always_comb begin
        hazard = valid_q && mem_rd_q && (wr_addr_q != '0) && in_valid &&
                 ((in_rs_addr == wr_addr_q) || (in_rt_addr == wr_addr_q));
        in_ready = !flush && !hazard && (!valid_q || out_ready);
        in_fire  = in_valid && in_ready;
        out_fire = valid_q && out_ready;
    end

    always_comb begin
        valid_d   = valid_q;
        rs_addr_d = rs_addr_q;
        rt_addr_d = rt_addr_q;
        wr_addr_d = wr_addr_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        mem_rd_d  = mem_rd_q;
        ctrl_d    = ctrl_q;

        if (in_fire) begin
            valid_d   = 1'b1;
            rs_addr_d = in_rs_addr;
            rt_addr_d = in_rt_addr;
            wr_addr_d = in_wr_addr;
            rs_data_d = pick_operand(in_rs_addr, in_rs_data, fwd_en, fwd_addr, fwd_data);
            rt_data_d = pick_operand(in_rt_addr, in_rt_data, fwd_en, fwd_addr, fwd_data);
            mem_rd_d  = in_mem_rd;
            ctrl_d    = in_ctrl;
        end else if (out_fire) begin
            valid_d = 1'b0;
        end else if (valid_q && fwd_en && (fwd_addr != '0)) begin
            // A stalled slot must not keep a stale operand once its producer completes.
            if (fwd_addr == rs_addr_q) rs_data_d = fwd_data;
            if (fwd_addr == rt_addr_q) rt_data_d = fwd_data;
        end

        if (flush)
            valid_d = 1'b0;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (hazard && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q   <= 1'b0;
            rs_addr_q <= '0;
            rt_addr_q <= '0;
            wr_addr_q <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            mem_rd_q  <= 1'b0;
            ctrl_q    <= '0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            rs_addr_q <= rs_addr_d;
            rt_addr_q <= rt_addr_d;
            wr_addr_q <= wr_addr_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            mem_rd_q  <= mem_rd_d;
            ctrl_q    <= ctrl_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_rs_addr = rs_addr_q;
    assign out_rt_addr = rt_addr_q;
    assign out_wr_addr = wr_addr_q;
    assign out_rs_data = rs_data_q;
    assign out_rt_data = rt_data_q;
    assign out_mem_rd  = mem_rd_q;
    assign out_ctrl    = ctrl_q;
    assign stall_cnt   = cnt_q;

endmodule
